// File: rtl/button_event_fifo_pkg.sv
// Shared helpers for button_event_fifo: index width and stored-entry field offsets.
// Entry layout: {timestamp (only with BUTTON_FIFO_TIMESTAMP_EN), button index}.
package button_event_fifo_pkg;

  localparam int unsigned ENTRY_IDX_LSB = 0;

  // Bits needed to encode a button index among n buttons.
  function automatic int unsigned btn_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Timestamp field sits directly above the index field.
  function automatic int unsigned entry_ts_lsb(input int unsigned n);
    return ENTRY_IDX_LSB + btn_idx_w(n);
  endfunction

endpackage

// File: rtl/button_event_fifo_sync_fifo.sv
// sync_fifo: first-word-fall-through storage with pointers, occupancy count and sync reset.
// A write is accepted when not full, or when full and a read fires in the same cycle.
module sync_fifo #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_wr_en,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rd_en,
  output logic [DATA_W-1:0]        o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_rd;
  logic              w_wr;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  // Storage is cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/button_event_fifo.sv
// button_event_fifo: serializes button press pulses (lowest index first) into an event FIFO.
// Optional macro BUTTON_FIFO_TIMESTAMP_EN stores a free-running timestamp per entry and adds ts_out.
module button_event_fifo
  import button_event_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           pulses,
  input  logic                       rd_en,
  input  logic                       clr_dropped,
  output logic [$clog2(WIDTH)-1:0]   dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       dropped
`ifdef BUTTON_FIFO_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]        ts_out
`endif
);

  localparam int unsigned IDX_W = btn_idx_w(WIDTH);
`ifdef BUTTON_FIFO_TIMESTAMP_EN
  localparam int unsigned TS_LSB  = entry_ts_lsb(WIDTH);
  localparam int unsigned ENTRY_W = IDX_W + TS_WIDTH;
`else
  localparam int unsigned ENTRY_W = IDX_W;
`endif

  logic [WIDTH-1:0]   r_pending;
  logic               r_dropped;
  logic [WIDTH-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_pop;
  logic               w_blocked;
  logic               w_push;
  logic               w_drop_set;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_rd_entry;

  assign w_pop      = rd_en && !empty;
  assign w_blocked  = full && !w_pop;
  assign w_push     = |w_grant;
  assign w_drop_set = |(pulses & r_pending & ~w_grant);

  // Lowest pending button wins; descending scan leaves the lowest index last.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    if (!w_blocked) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (r_pending[i]) begin
          w_grant    = '0;
          w_grant[i] = 1'b1;
          w_idx      = IDX_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_grant) | pulses;
      if (w_drop_set)       r_dropped <= 1'b1;
      else if (clr_dropped) r_dropped <= 1'b0;
    end
  end

  assign dropped = r_dropped;

`ifdef BUTTON_FIFO_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (rst) r_ts <= '0;
    else     r_ts <= r_ts + TS_WIDTH'(1);
  end

  assign w_wr_entry = {r_ts, w_idx};
  assign ts_out     = w_rd_entry[TS_LSB +: TS_WIDTH];
`else
  assign w_wr_entry = w_idx;
`endif

  assign dout = w_rd_entry[ENTRY_IDX_LSB +: IDX_W];

  sync_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push),
    .i_wr_data (w_wr_entry),
    .i_rd_en   (rd_en),
    .o_rd_data (w_rd_entry),
    .o_empty   (empty),
    .o_full    (full),
    .o_count   (count)
  );

endmodule

// File: tb/tb_button_event_fifo.sv
// Directed self-checking bench for button_event_fifo (WIDTH=4, DEPTH=8).
// With BUTTON_FIFO_TIMESTAMP_EN defined, also checks timestamp spacing on ts_out.
module tb_button_event_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] pulses;
  logic       rd_en;
  logic       clr_dropped;
  logic [1:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       dropped;
`ifdef BUTTON_FIFO_TIMESTAMP_EN
  logic [15:0] ts_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  button_event_fifo #(.WIDTH(4), .DEPTH(8), .TS_WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pulses      (pulses),
    .rd_en       (rd_en),
    .clr_dropped (clr_dropped),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .dropped     (dropped)
`ifdef BUTTON_FIFO_TIMESTAMP_EN
    ,
    .ts_out      (ts_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one active edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop every modelled entry, comparing the head each time.
  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_head"}, 32'(dout), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    check({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    logic [1:0] held;
`ifdef BUTTON_FIFO_TIMESTAMP_EN
    logic [15:0] ts_a;
`endif
    pulses = '0; rd_en = 1'b0; clr_dropped = 1'b0; rst = 1'b1;
    #1;

    // 1: reset
    tick(); tick();
    rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dropped", 32'(dropped), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);

    // 2: single press on button 2
    pulses = 4'b0100; tick(); pulses = '0;
    check("single_lat_empty", 32'(empty), 32'd1);
    tick();
    check("single_empty", 32'(empty), 32'd0);
    check("single_dout", 32'(dout), 32'd2);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("single_pop_empty", 32'(empty), 32'd1);
    held = dout;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("rd_empty_count", 32'(count), 32'd0);
    check("rd_empty_dout_hold", 32'(dout), 32'(held));

    // 3: simultaneous press serialized lowest first
    pulses = 4'b1011; tick(); pulses = '0;
    tick(); tick(); tick();
    check("simul_count", 32'(count), 32'd3);
    exp_q = '{0, 1, 3};
    drain("simul");
    check("simul_dropped", 32'(dropped), 32'd0);

    // 4: fill to DEPTH, then overflow into pending
    for (int k = 0; k < 8; k++) begin
      pulses = 4'(1 << (k % 4));
      exp_q.push_back(k % 4);
      tick();
    end
    pulses = '0; tick();
    check("full_flag", 32'(full), 32'd1);
    check("full_count", 32'(count), 32'd8);
    pulses = 4'b0010; tick();
    check("full_hold_count", 32'(count), 32'd8);
    check("full_no_drop_yet", 32'(dropped), 32'd0);
    pulses = 4'b0010; clr_dropped = 1'b1; tick();
    pulses = '0; clr_dropped = 1'b0;
    check("drop_set_beats_clr", 32'(dropped), 32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    void'(exp_q.pop_front()); exp_q.push_back(1);
    check("full_pushpop_count", 32'(count), 32'd8);
    check("full_pushpop_head", 32'(dout), 32'd1);
    tick();
    check("full_idle_count", 32'(count), 32'd8);

    // 5: push+pop while full preserves order
    pulses = 4'b1000; tick(); pulses = '0;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    void'(exp_q.pop_front()); exp_q.push_back(3);
    check("pushpop2_count", 32'(count), 32'd8);
    check("pushpop2_full", 32'(full), 32'd1);
    drain("order");
    clr_dropped = 1'b1; tick(); clr_dropped = 1'b0;
    check("clr_dropped", 32'(dropped), 32'd0);

    // 6: reset mid-stream with queued and pending events
    pulses = 4'b0001; tick();
    pulses = 4'b0010; tick();
    pulses = 4'b0100; tick();
    pulses = 4'b1000; tick();
    pulses = '0;
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_empty", 32'(empty), 32'd1);
    check("mid_rst_dout", 32'(dout), 32'd0);
    tick(); tick(); tick();
    check("no_stale_event", 32'(empty), 32'd1);

`ifdef BUTTON_FIFO_TIMESTAMP_EN
    // Two presses 5 edges apart are stamped 5 apart.
    pulses = 4'b0001; tick(); pulses = '0;
    for (int k = 0; k < 4; k++) tick();
    pulses = 4'b0010; tick(); pulses = '0;
    tick();
    ts_a = ts_out;
    check("ts_first_dout", 32'(dout), 32'd0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("ts_second_dout", 32'(dout), 32'd1);
    check("ts_delta", 32'(16'(ts_out - ts_a)), 32'd5);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
